// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
//   DEF_WIDTH  : default data word width
//   DEF_ADDR_W : default address width (DEPTH = 2**ADDR_W)
//   ptr_width(): pointer width for a given address width (one extra wrap bit)
package fifo_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 4;

    // Pointers carry one bit above the address so full and empty can be told apart.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
//   clr, wr, wr_data, rd             : requests from the user
//   rd_data, rd_valid                : registered read return
//   full, empty, almost_full,
//   almost_empty, count              : registered occupancy status
//   overflow, underflow              : sticky error flags
interface sync_fifo_if #(
    parameter int WIDTH  = fifo_pkg::DEF_WIDTH,
    parameter int ADDR_W = fifo_pkg::DEF_ADDR_W
);
    logic              clr;
    logic              wr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr, wr_data, rd,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr, wr_data, rd,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, registered read.
//   clk, rst : clock; rst clears only the read register, never the array
//   we, waddr, wdata : write port
//   re, raddr, rdata : read port, rdata updates the cycle after re and holds otherwise
// A read and write to the same address in one cycle returns the old word.
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage array write port; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer/flag control around a fifo_mem storage block.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, dominates everything
//   bus : sync_fifo_if slave (clr/wr/rd requests, data, registered status)
// All status outputs are computed from the next pointer values and registered,
// so count and every flag change in the same cycle as the pointers.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = ptr_width(ADDR_W);
    localparam logic [PTR_W-1:0] AF_C = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_C = PTR_W'(AE_LEVEL);

    if (ADDR_W < 1 || AE_LEVEL <= 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= DEPTH) begin : g_bad_params
        $error("sync_fifo: illegal parameters, need ADDR_W>=1 and 0 < AE_LEVEL < AF_LEVEL < DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             rd_valid_r;

    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] count_nxt_s;
    logic             full_nxt_s;
    logic             empty_nxt_s;
    logic             overflow_nxt_s;
    logic             underflow_nxt_s;
    logic             mem_we_s;
    logic             mem_re_s;

    // A simultaneous read frees a slot, so a write on full is still taken.
    assign rd_acc_s = bus.rd & ~empty_r;
    assign wr_acc_s = bus.wr & (~full_r | rd_acc_s);

    // Next pointer, occupancy and flag values derived from this cycle's accepts.
    always_comb begin
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // Modular difference of wrap-bit pointers yields 0..DEPTH directly.
        count_nxt_s     = wr_ptr_nxt_s - rd_ptr_nxt_s;
        empty_nxt_s     = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s      = (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]) &&
                          (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]);
        overflow_nxt_s  = overflow_r | (bus.wr & full_r & ~rd_acc_s);
        underflow_nxt_s = underflow_r | (bus.rd & empty_r);
    end

    // Control state: reset dominates flush, flush dominates wr/rd.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            rd_valid_r     <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            count_r        <= count_nxt_s;
            full_r         <= full_nxt_s;
            empty_r        <= empty_nxt_s;
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
            overflow_r     <= overflow_nxt_s;
            underflow_r    <= underflow_nxt_s;
            rd_valid_r     <= rd_acc_s;
        end
    end

    // Flush and reset cancel any storage access in the same cycle.
    assign mem_we_s = wr_acc_s & ~bus.clr & ~rst;
    assign mem_re_s = rd_acc_s & ~bus.clr & ~rst;

    fifo_mem #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .re    (mem_re_s),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid     = rd_valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries (16 by default).
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-005 Parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clr  input  1  synchronous flush: empties the FIFO and clears sticky flags; stored data is not erased.
REQ-009 wr  input  1  write request, sampled at rising clk.
REQ-010 wr_data  input  WIDTH  write data, captured with an accepted write.
REQ-011 rd  input  1  read request, sampled at rising clk.
REQ-012 rd_data  output  WIDTH  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data is new this cycle.
REQ-014 full, empty  output  1 each  registered occupancy flags.
REQ-015 almost_full, almost_empty  output  1 each  registered threshold flags.
REQ-016 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Pointers SHALL be ADDR_W+1 bits; the MSB is a wrap bit. empty = (wr_ptr == rd_ptr). full = (address bits equal, wrap bits differ).
REQ-019 A write SHALL be accepted when wr && (!full || rd_acc); an accepted write stores wr_data at wr_ptr and increments wr_ptr modulo 2*DEPTH.
REQ-020 A read SHALL be accepted (rd_acc) when rd && !empty; an accepted read increments rd_ptr.
REQ-021 Read latency SHALL be 1 cycle: the entry at rd_ptr appears on rd_data in the cycle after rd_acc, with rd_valid=1 in that cycle. rd_data holds its value otherwise.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged. On full, wr+rd: both are accepted. On empty, wr+rd: only the write is accepted and underflow is set.
REQ-023 count, full, empty, almost_full and almost_empty SHALL all update in the same cycle as the pointer change; they are registered and mutually consistent every cycle.
REQ-024 wr while full without rd_acc SHALL drop the data and set overflow; rd while empty SHALL set underflow. Both flags stay set until rst or clr.
REQ-025 clr SHALL take priority over wr and rd in the same cycle: pointers go to 0, count=0, empty=1, full=0, overflow=underflow=0, rd_valid=0.
REQ-026 Pointer wrap past 2*DEPTH-1 SHALL return to 0 without disturbing the flags.
REQ-027 Parameter legality SHALL be checked at elaboration: ADDR_W>=1 and 0 < AE_LEVEL < AF_LEVEL < DEPTH.

Reset
REQ-028 rst SHALL dominate clr, wr and rd. Next-cycle values: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, rd_valid=0, rd_data=0.
REQ-029 rst asserted mid-transfer SHALL abandon the in-flight read; storage contents are not cleared.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default WIDTH/ADDR_W constants and a pointer-width helper function.
REQ-031 Storage SHALL be a sub-module fifo_mem: simple dual-port, synchronous write, synchronous registered read. Control and flag logic stay in sync_fifo.

Verification (WIDTH=8, ADDR_W=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Reset, then write 0xA1,0xB2,0xC3,0xD4 -> full=1, count=4, almost_full set from count=3; a 5th write sets overflow=1 and count stays 4.
REQ-033 From full, read 4 times -> rd_data 0xA1,0xB2,0xC3,0xD4 each one cycle after rd, with rd_valid pulses; then empty=1 and almost_empty=1.
REQ-034 While full, wr=rd=1 with wr_data=0x55 -> count stays 4, the oldest word is returned, and 0x55 is read last.
REQ-035 While empty, wr=rd=1 with 0x77 -> count=1, underflow=1, no rd_valid; the next read returns 0x77.
REQ-036 Run 20 write/read pairs (pointer wrap ×2) -> data order preserved with no spurious flags; then clr with wr=1 -> count=0 and the write is ignored.
REQ-037 Assert rst with count=3 and rd=1 -> the next cycle shows all reset values of REQ-028 and no rd_valid.
